// File: rtl/sumador_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   flags_t   : status flags produced with every result
//   chunk_ok  : parameter legality check used at elaboration time
package sumador_pkg;

    typedef struct packed {
        logic c_out;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Operand width must be at least 2 and split evenly into CHUNK-bit slices.
    function automatic bit chunk_ok(input int n, input int chunk);
        return (n >= 2) && (chunk > 0) && ((n % chunk) == 0);
    endfunction

endpackage

// File: rtl/sumador_etapa.sv
// One CHUNK-bit pipeline stage of sumador_segmentado.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_valid / o_valid : valid from the previous stage / this stage's valid
//   i_en_next / o_en  : load enable of the next stage / of this stage
//   i_a, i_b          : operand A and (possibly inverted) operand B, full width
//   i_sum             : partial sum, slices below IDX already filled in
//   i_carry, i_zero   : carry into slice IDX, running "all lower slices zero"
//   o_*               : registered copies handed to the next stage
module sumador_etapa
    import sumador_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic         i_en_next,
    output logic         o_en,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_sum,
    input  logic         i_carry,
    input  logic         i_zero,
    output logic         o_valid,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b,
    output logic [N-1:0] o_sum,
    output logic         o_carry,
    output logic         o_zero
);

    logic [CHUNK:0] w_slice;
    logic [N-1:0]   w_sum_next;

    logic           r_valid;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_sum;
    logic           r_carry;
    logic           r_zero;

    // Behavioural slice adder; the extra MSB is the carry out of the slice.
    assign w_slice = {1'b0, i_a[IDX*CHUNK +: CHUNK]}
                   + {1'b0, i_b[IDX*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, i_carry};

    // NOTE: every always_comb output gets a full default first, so a partial
    // update below can never leave a path that infers a latch.
    always_comb begin
        w_sum_next = i_sum;
        w_sum_next[IDX*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
    end

    // A stage can load when it is empty or when its contents move on this edge.
    assign o_en = !r_valid || i_en_next;

    // NOTE: state uses non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; blocking here would shoot data through.
    // NOTE: the data registers are reset as well as the valid bit, so the
    // outputs read all-zero after reset rather than stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (o_en) begin
            r_valid <= i_valid;
            // Bubbles only clear the valid bit; data is left untouched.
            if (i_valid) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_sum   <= w_sum_next;
                r_carry <= w_slice[CHUNK];
                r_zero  <= i_zero && (w_slice[CHUNK-1:0] == '0);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_sum   = r_sum;
    assign o_carry = r_carry;
    assign o_zero  = r_zero;

endmodule

// File: rtl/sumador_segmentado.sv
// Pipelined N-bit adder/subtractor, CHUNK bits per stage, valid/ready on both
// sides, one operation per cycle, latency N/CHUNK cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready may depend on out_ready)
//   a, b, c_in, sub     : sub=0 -> a+b+c_in, sub=1 -> a+~b+c_in
//   out_valid/out_ready : result handshake
//   sum, c_out, ovf, zero, neg : result and flags, straight from registers
module sumador_segmentado
    import sumador_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int STAGES = N / CHUNK;

    if (!chunk_ok(N, CHUNK)) begin : g_bad_params
        $error("sumador_segmentado: N must be >= 2 and a multiple of CHUNK");
    end

    typedef struct packed {
        logic [N-1:0] sum;
        flags_t       flags;
    } result_t;

    // Index k is the input of stage k; index STAGES is the last stage's output.
    logic [STAGES:0][N-1:0] w_a;
    logic [STAGES:0][N-1:0] w_b;
    logic [STAGES:0][N-1:0] w_sum;
    logic [STAGES:0]        w_carry;
    logic [STAGES:0]        w_zero;
    logic [STAGES:0]        w_valid;
    logic [STAGES:0]        w_en;
    result_t                w_res;

    assign w_a[0]       = a;
    assign w_b[0]       = sub ? ~b : b;
    assign w_sum[0]     = '0;
    assign w_carry[0]   = c_in;
    assign w_zero[0]    = 1'b1;
    assign w_valid[0]   = in_valid;
    assign w_en[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_etapa
        sumador_etapa #(
            .N     (N),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_etapa (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_valid   (w_valid[k]),
            .i_en_next (w_en[k+1]),
            .o_en      (w_en[k]),
            .i_a       (w_a[k]),
            .i_b       (w_b[k]),
            .i_sum     (w_sum[k]),
            .i_carry   (w_carry[k]),
            .i_zero    (w_zero[k]),
            .o_valid   (w_valid[k+1]),
            .o_a       (w_a[k+1]),
            .o_b       (w_b[k+1]),
            .o_sum     (w_sum[k+1]),
            .o_carry   (w_carry[k+1]),
            .o_zero    (w_zero[k+1])
        );
    end

    // Only the sign bits of the delayed operands matter after the last stage.
    logic w_unused_low_bits;
    assign w_unused_low_bits = ^{w_a[STAGES][N-2:0], w_b[STAGES][N-2:0]};

    // Flags are pure functions of last-stage registers; nothing from the inputs.
    assign w_res.sum         = w_sum[STAGES];
    assign w_res.flags.c_out = w_carry[STAGES];
    assign w_res.flags.ovf   = (w_a[STAGES][N-1] == w_b[STAGES][N-1])
                            && (w_sum[STAGES][N-1] != w_a[STAGES][N-1]);
    assign w_res.flags.zero  = w_zero[STAGES];
    assign w_res.flags.neg   = w_sum[STAGES][N-1];

    assign in_ready  = w_en[0];
    assign out_valid = w_valid[STAGES];
    assign sum       = w_res.sum;
    assign c_out     = w_res.flags.c_out;
    assign ovf       = w_res.flags.ovf;
    assign zero      = w_res.flags.zero;
    assign neg       = w_res.flags.neg;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed and random-stream bench for sumador_segmentado in three shapes:
// dut 0 = N8/CHUNK4, dut 1 = N16/CHUNK16, dut 2 = N16/CHUNK4.
module tb_sumador_segmentado;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_d;
    logic [15:0] b_d;
    logic        cin_d;
    logic        sub_d;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  c_out;
    logic [2:0]  ovf;
    logic [2:0]  zero;
    logic [2:0]  neg;
    logic [7:0]  sum0;
    logic [15:0] sum1;
    logic [15:0] sum2;

    int n_cmp = 0;
    int n_bad = 0;

    sumador_segmentado #(.N(8), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_d[7:0]), .b(b_d[7:0]), .c_in(cin_d), .sub(sub_d),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum0), .c_out(c_out[0]), .ovf(ovf[0]), .zero(zero[0]), .neg(neg[0])
    );

    sumador_segmentado #(.N(16), .CHUNK(16)) u_dut16_1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_d), .b(b_d), .c_in(cin_d), .sub(sub_d),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum1), .c_out(c_out[1]), .ovf(ovf[1]), .zero(zero[1]), .neg(neg[1])
    );

    sumador_segmentado #(.N(16), .CHUNK(4)) u_dut16_4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_d), .b(b_d), .c_in(cin_d), .sub(sub_d),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum2), .c_out(c_out[2]), .ovf(ovf[2]), .zero(zero[2]), .neg(neg[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got %0d compared, required completion", n_cmp);
        $fatal(1, "watchdog");
    end

    // {in_ready, out_valid, c_out, ovf, zero, neg, sum zero-extended to 16}
    function automatic logic [21:0] obs(input int sel);
        logic [15:0] s;
        case (sel)
            0:       s = {8'h00, sum0};
            1:       s = sum1;
            default: s = sum2;
        endcase
        return {in_ready[sel], out_valid[sel], c_out[sel], ovf[sel], zero[sel], neg[sel], s};
    endfunction

    function automatic logic [19:0] res(input logic c, input logic o, input logic z,
                                        input logic n, input logic [15:0] s);
        return {c, o, z, n, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, input logic vld, input logic rdy);
        a_d            = a;
        b_d            = b;
        cin_d          = cin;
        sub_d          = sb;
        in_valid       = '0;
        in_valid[sel]  = vld;
        out_ready      = '1;
        out_ready[sel] = rdy;
    endtask

    // Presents one operand for one cycle, then counts cycles until out_valid.
    task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, output int lat);
        logic [21:0] o;
        drive(sel, a, b, cin, sb, 1'b1, 1'b1);
        #1;
        o = obs(sel);
        chk("issue_in_ready", {31'b0, o[21]}, 32'd1);
        @(negedge clk);
        in_valid = '0;
        lat = 1;
        o = obs(sel);
        while (!o[20] && lat < 20) begin
            @(negedge clk);
            lat++;
            o = obs(sel);
        end
    endtask

    // Random operands and random out_ready against an arithmetic reference.
    task automatic rand_stream(input int sel, input int n_ops);
        logic [19:0] q[$];
        logic [19:0] e;
        logic [21:0] o;
        logic [15:0] ra, rb, bp;
        logic [16:0] full;
        logic        rc, rs, v, r;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        while (got < n_ops && cyc < 3000) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            v  = (sent < n_ops) && ($urandom_range(3) != 0);
            r  = ($urandom_range(2) != 0);
            drive(sel, ra, rb, rc, rs, v, r);
            #1;
            o = obs(sel);
            if (o[20] && r) begin
                if (q.size() == 0) begin
                    chk("rs_unexpected_out", q.size(), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("rs_result", {12'b0, o[19:0]}, {12'b0, e});
                end
                got++;
            end
            if (v && o[21]) begin
                bp   = rs ? ~rb : rb;
                full = {1'b0, ra} + {1'b0, bp} + {16'b0, rc};
                e = {full[16], (ra[15] == bp[15]) && (full[15] != ra[15]),
                     full[15:0] == 16'h0000, full[15], full[15:0]};
                q.push_back(e);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rs_count", got, n_ops);
        in_valid  = '0;
        out_ready = '1;
    endtask

    initial begin
        int          lat;
        logic [21:0] o;
        logic [7:0]  rx[$];
        logic [7:0]  exp4 [4];
        int          sent;
        int          got;
        int          stall;
        int          seen;
        int          held_low;
        int          extra;

        exp4 = '{8'h02, 8'h04, 8'h06, 8'h08};

        // Reset state.
        rst_n = 1'b0;
        drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        for (int s = 0; s < 3; s++) begin
            o = obs(s);
            chk("reset_state", {10'b0, o}, {10'b0, 1'b1, 1'b0, 20'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 0x3A + 0x47 = 0x81, signed overflow, latency 2.
        issue(0, 16'h003A, 16'h0047, 1'b0, 1'b0, lat);
        chk("t1_latency", lat, 2);
        o = obs(0);
        chk("t1_add_ovf", {12'b0, o[19:0]}, {12'b0, res(1'b0, 1'b1, 1'b0, 1'b1, 16'h0081)});

        // 2: 0xFF + 0x01 wraps to zero with carry.
        issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        chk("t2_latency", lat, 2);
        o = obs(0);
        chk("t2_wrap_zero", {12'b0, o[19:0]}, {12'b0, res(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000)});

        // 3: subtraction with borrow, then signed overflow on subtract.
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        o = obs(0);
        chk("t3_sub_borrow", {12'b0, o[19:0]}, {12'b0, res(1'b0, 1'b0, 1'b0, 1'b1, 16'h00FE)});
        issue(0, 16'h0080, 16'h0001, 1'b1, 1'b1, lat);
        o = obs(0);
        chk("t3_sub_ovf", {12'b0, o[19:0]}, {12'b0, res(1'b1, 1'b1, 1'b0, 1'b0, 16'h007F)});
        @(negedge clk);

        // 4: four back-to-back operands, consumer stalls 3 cycles at first result.
        sent = 0; got = 0; stall = 0; seen = 0; held_low = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid[0] && seen == 0) begin
                seen  = 1;
                stall = 3;
            end
            drive(0, 16'(sent + 1), 16'(sent + 1), 1'b0, 1'b0, sent < 4, stall == 0);
            #1;
            if (stall > 0) begin
                chk("t4_stall_sum", {24'b0, sum0}, 32'h02);
                chk("t4_stall_valid", {31'b0, out_valid[0]}, 32'd1);
                if (!in_ready[0]) held_low++;
                stall--;
            end
            if (in_valid[0] && in_ready[0]) sent++;
            if (out_valid[0] && out_ready[0]) begin
                rx.push_back(sum0);
                got++;
            end
            @(negedge clk);
        end
        chk("t4_in_ready_low", held_low, 3);
        chk("t4_count", rx.size(), 4);
        if (rx.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t4_order", {24'b0, rx[i]}, {24'b0, exp4[i]});
        end
        in_valid = '0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid[0]) extra++;
            @(negedge clk);
        end
        chk("t4_no_extra", extra, 0);

        // 5: reset with two transactions in flight.
        drive(0, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 16'h0033, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = '0;
        #1;
        chk("t5_in_flight", {31'b0, out_valid[0]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        o = obs(0);
        chk("t5_reset_outputs", {10'b0, o}, {10'b0, 1'b1, 1'b0, 20'h0});
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid[0]) extra++;
            @(negedge clk);
        end
        chk("t5_no_ghost", extra, 0);
        issue(0, 16'h0010, 16'h0020, 1'b0, 1'b0, lat);
        chk("t5_latency", lat, 2);
        o = obs(0);
        chk("t5_after_reset", {12'b0, o[19:0]}, {12'b0, res(1'b0, 1'b0, 1'b0, 1'b0, 16'h0030)});
        @(negedge clk);

        // 6: 16-bit shapes, latency and full-width wrap.
        issue(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("t6_lat_single", lat, 1);
        o = obs(1);
        chk("t6_wrap_single", {12'b0, o[19:0]}, {12'b0, res(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000)});
        @(negedge clk);
        issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("t6_lat_four", lat, 4);
        o = obs(2);
        chk("t6_wrap_four", {12'b0, o[19:0]}, {12'b0, res(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000)});
        @(negedge clk);
        issue(2, 16'h7FF0, 16'h0010, 1'b0, 1'b0, lat);
        o = obs(2);
        chk("t6_ovf_four", {12'b0, o[19:0]}, {12'b0, res(1'b0, 1'b1, 1'b0, 1'b1, 16'h8000)});
        @(negedge clk);

        rand_stream(1, 60);
        rand_stream(2, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
